// File: rtl/exception_status_unit.sv
// rtl/exception_status_unit.sv - exception arbitration, pending FIFO, sticky causes and drop counter
// Optional build macro: EXC_TIMESTAMP_EN (adds a 16-bit push timestamp in status_data[DATA_W-1 -: 16])
module exception_status_unit #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int CODE_W  = 5,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*CODE_W-1:0] src_code,
  input  logic                      flush,
  input  logic                      status_ready,
  output logic                      status_valid,
  output logic [DATA_W-1:0]         status_data,
  output logic [SRC_W-1:0]          status_src,
  output logic [CNT_W-1:0]          pending_count,
  output logic [7:0]                drop_count,
  output logic [NUM_SRC-1:0]        cause_sticky,
  input  logic                      clear_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
`ifdef EXC_TIMESTAMP_EN
  localparam int ENT_W = 16 + SRC_W + CODE_W;
`else
  localparam int ENT_W = SRC_W + CODE_W;
`endif

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [NUM_SRC-1:0] active;
  logic [SRC_W-1:0]   win_idx;
  logic [CODE_W-1:0]  win_code;
  logic               any_active;
  logic [8:0]         n_active;
  logic               pop;
  logic               push;
  logic [8:0]         drop_inc;
  logic [9:0]         drop_sum;
  logic [ENT_W-1:0]   head;
  logic [ENT_W-1:0]   new_entry;

`ifdef EXC_TIMESTAMP_EN
  logic [15:0] ts;

  // Free-running cycle counter sampled into each entry at its push edge
  always_ff @(posedge clock) begin
    if (reset) ts <= '0;
    else       ts <= ts + 16'd1;
  end

  assign new_entry = {ts, win_idx, win_code};
`else
  assign new_entry = {win_idx, win_code};
`endif

  // Qualify requests and pick the lowest-index active source; scanning downward leaves the lowest winner
  always_comb begin
    active     = '0;
    win_idx    = '0;
    win_code   = '0;
    any_active = 1'b0;
    n_active   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      active[i] = src_valid[i] && (src_code[i*CODE_W +: CODE_W] != '0);
      if (active[i]) begin
        win_idx    = SRC_W'(i);
        win_code   = src_code[i*CODE_W +: CODE_W];
        any_active = 1'b1;
        n_active   = n_active + 9'd1;
      end
    end
  end

  assign pop  = status_valid && status_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push = any_active && !flush && ((count < CNT_W'(DEPTH)) || pop);
  // Every active request that does not get enqueued is a drop, unless flush discards the whole cycle
  assign drop_inc = flush ? 9'd0 : (n_active - {8'd0, push});
  assign drop_sum = {2'b00, drop_count} + {1'b0, drop_inc};

  // Pending FIFO: flush empties it and takes priority over push and pop
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Saturating drop counter; all of a cycle's increments are summed before clamping
  always_ff @(posedge clock) begin
    if (reset)                  drop_count <= '0;
    else if (drop_sum > 10'd255) drop_count <= 8'd255;
    else                        drop_count <= drop_sum[7:0];
  end

  // Sticky causes: a new set in the same cycle survives clear_sticky
  always_ff @(posedge clock) begin
    if (reset) cause_sticky <= '0;
    else       cause_sticky <= (clear_sticky ? '0 : cause_sticky) | active;
  end

  assign head          = mem[rd_ptr];
  assign status_valid  = (count != '0);
  assign pending_count = count;
  assign status_src    = status_valid ? head[CODE_W +: SRC_W] : '0;

  // Head entry presented zero-extended; everything is forced to 0 while empty
  always_comb begin
    status_data = '0;
    if (status_valid) begin
      status_data[CODE_W-1:0] = head[CODE_W-1:0];
`ifdef EXC_TIMESTAMP_EN
      status_data[DATA_W-1 -: 16] = head[ENT_W-1 -: 16];
`endif
    end
  end

endmodule

// File: tb/tb_exception_status_unit.sv
// tb/tb_exception_status_unit.sv - scoreboard bench with reference model for exception_status_unit
module tb_exception_status_unit;

  localparam int DEPTH = 4;
`ifdef EXC_TIMESTAMP_EN
  localparam logic [31:0] DMASK = 32'h0000_ffff;
`else
  localparam logic [31:0] DMASK = 32'hffff_ffff;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  src_valid;
  logic [19:0] src_code;
  logic        flush;
  logic        status_ready;
  logic        clear_sticky;
  logic        status_valid;
  logic [31:0] status_data;
  logic [1:0]  status_src;
  logic [2:0]  pending_count;
  logic [7:0]  drop_count;
  logic [3:0]  cause_sticky;

  exception_status_unit dut (
    .clock(clock), .reset(reset), .src_valid(src_valid), .src_code(src_code),
    .flush(flush), .status_ready(status_ready), .status_valid(status_valid),
    .status_data(status_data), .status_src(status_src), .pending_count(pending_count),
    .drop_count(drop_count), .cause_sticky(cause_sticky), .clear_sticky(clear_sticky)
  );

  always #5 clock = ~clock;

  typedef struct { int src; int code; } ent_t;
  ent_t mq[$];     // model FIFO contents
  ent_t exp_q[$];  // scoreboard: entries expected to be delivered
  int   mdrop;
  logic [3:0] msticky;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model the effect of the coming clock edge from the inputs being driven now
  task automatic model_step();
    int first;
    int n;
    logic [3:0] act;
    if (reset) begin
      mq.delete();
      mdrop   = 0;
      msticky = 4'b0;
      return;
    end
    act = 4'b0;
    first = -1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (src_valid[i] && src_code[i*5 +: 5] != 5'd0) begin
        act[i] = 1'b1;
        n++;
        if (first < 0) first = i;
      end
    end
    msticky = (clear_sticky ? 4'b0 : msticky) | act;
    if (flush) begin
      mq.delete();
      return;
    end
    if (status_ready && mq.size() > 0) exp_q.push_back(mq.pop_front());
    if (first >= 0) begin
      if (mq.size() < DEPTH) mq.push_back('{first, int'(src_code[first*5 +: 5])});
      else mdrop++;
      mdrop += n - 1;
    end
    if (mdrop > 255) mdrop = 255;
  endtask

  task automatic check_state();
    chk("status_valid", {31'd0, status_valid}, {31'd0, mq.size() != 0});
    chk("pending_count", {29'd0, pending_count}, mq.size());
    chk("drop_count", {24'd0, drop_count}, mdrop);
    chk("cause_sticky", {28'd0, cause_sticky}, {28'd0, msticky});
    if (mq.size() == 0) begin
      chk("idle_data", status_data, 32'd0);
      chk("idle_src", {30'd0, status_src}, 32'd0);
    end else begin
      chk("head_data", status_data & DMASK, mq[0].code);
      chk("head_src", {30'd0, status_src}, mq[0].src);
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] v, input logic [19:0] c,
                     input logic f, input logic rd, input logic cl);
    reset = r; src_valid = v; src_code = c; flush = f; status_ready = rd; clear_sticky = cl;
    model_step();
    @(posedge clock);
    #1;
    check_state();
  endtask

  // Monitor: a handshake seen before the edge means the head is delivered at that edge
  always @(negedge clock) begin
    if (reset === 1'b0 && flush === 1'b0 && status_valid === 1'b1 && status_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deliver: unexpected entry data %0h src %0d", status_data, status_src);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("deliver_data", status_data & DMASK, e.code);
        chk("deliver_src", {30'd0, status_src}, e.src);
      end
    end
  end

  initial begin
    // 1: reset with source activity
    cyc(1, 4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, 0, 0, 0);
    cyc(1, 4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, 0, 1, 0);
    chk("reset_drop", {24'd0, drop_count}, 32'd0);
    // 2: single request, held, then popped
    cyc(0, 4'b0001, {15'd0, 5'd1}, 0, 0, 0);
    chk("first_data", status_data & DMASK, 32'd1);
    cyc(0, 4'b0000, 20'd0, 0, 0, 0);
    cyc(0, 4'b0000, 20'd0, 0, 1, 0);
    chk("popped_valid", {31'd0, status_valid}, 32'd0);
    // 3: two simultaneous requests, lower index wins
    cyc(1, 4'b0000, 20'd0, 0, 0, 0);
    cyc(0, 4'b0110, {5'd0, 5'd2, 5'd3, 5'd0}, 0, 0, 0);
    chk("arb_drop", {24'd0, drop_count}, 32'd1);
    chk("arb_sticky", {28'd0, cause_sticky}, 32'h6);
    cyc(0, 4'b0000, 20'd0, 0, 1, 0);
    // 4: overfill, push+pop while full, drain
    cyc(1, 4'b0000, 20'd0, 0, 0, 0);
    cyc(0, 4'b0001, {15'd0, 5'd1}, 0, 0, 0);
    cyc(0, 4'b0001, {15'd0, 5'd2}, 0, 0, 0);
    cyc(0, 4'b0001, {15'd0, 5'd3}, 0, 0, 0);
    cyc(0, 4'b0001, {15'd0, 5'd1}, 0, 0, 0);
    cyc(0, 4'b0001, {15'd0, 5'd2}, 0, 0, 0);
    chk("full_count", {29'd0, pending_count}, 32'd4);
    cyc(0, 4'b0001, {15'd0, 5'd7}, 0, 1, 0);
    chk("full_pushpop", {29'd0, pending_count}, 32'd4);
    for (int i = 0; i < 5; i++) cyc(0, 4'b0000, 20'd0, 0, 1, 0);
    // 5: flush with a concurrent request
    cyc(1, 4'b0000, 20'd0, 0, 0, 0);
    cyc(0, 4'b0010, {10'd0, 5'd4, 5'd0}, 0, 0, 0);
    cyc(0, 4'b0100, {5'd0, 5'd5, 10'd0}, 0, 0, 0);
    cyc(0, 4'b0001, {15'd0, 5'd2}, 1, 1, 0);
    chk("flush_count", {29'd0, pending_count}, 32'd0);
    // 6: sticky clear vs set, then saturate drop_count
    cyc(1, 4'b0000, 20'd0, 0, 0, 0);
    cyc(0, 4'b0011, {10'd0, 5'd1, 5'd1}, 0, 1, 0);
    cyc(0, 4'b0010, {10'd0, 5'd1, 5'd0}, 0, 1, 1);
    chk("sticky_clear", {28'd0, cause_sticky}, 32'h2);
    for (int i = 0; i < 80; i++) cyc(0, 4'b1111, {5'd9, 5'd9, 5'd9, 5'd9}, 0, 0, 0);
    chk("drop_sat", {24'd0, drop_count}, 32'd255);
    // Randomized traffic
    cyc(1, 4'b0000, 20'd0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  v;
      logic [19:0] c;
      v = 4'($urandom);
      c = 20'($urandom);
      if ($urandom_range(0, 3) == 0) c[4:0] = 5'd0;
      cyc($urandom_range(0, 299) == 0, v, c, $urandom_range(0, 15) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 6; i++) cyc(0, 4'b0000, 20'd0, 0, 1, 0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
